// File: rtl/spi_eeprom_sequencer.sv
// Sequences byte reads/writes to an SPI EEPROM through a Wishbone-attached SPI controller.
// Each controller access is issued, held until acked, then followed by at least one idle cycle.
module spi_eeprom_sequencer #(
  parameter logic [31:0] BAUD_CFG = 32'h0000_0019,
  parameter logic [15:0] POLL_MAX = 16'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [7:0]  req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] wb_addr,
  output logic [31:0] wb_dout,
  output logic        wb_we,
  output logic        wb_stb,
  output logic        wb_cyc,
  input  logic [31:0] wb_din,
  input  logic        wb_ack
);

  typedef enum logic [3:0] {
    StInit, StIdle, StWren, StWInstr, StWAddr, StWData, StSInstr, StSRecv, StSPoll,
    StRInstr, StRAddr, StRRecv, StRPoll, StDone
  } state_e;

  state_e      state_q, next_st;
  logic        wait_q;
  logic [7:0]  addr_q, wdata_q;
  logic [15:0] cnt_q, cnt_inc;
  logic [7:0]  bus_addr_q;
  logic [31:0] bus_dout_q;
  logic        bus_we_q, bus_cyc_q;
  logic        req_ready_q, rsp_valid_q, rsp_err_q;
  logic [7:0]  rsp_rdata_q;
  logic        cmd_we;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        poll_st;
  logic        unused_din;

  // Access descriptor and successor for every non-poll bus state.
  always_comb begin
    cmd_we   = 1'b1;
    cmd_addr = 8'h10;
    cmd_data = '0;
    next_st  = state_q;
    case (state_q)
      StInit:   begin cmd_addr = 8'h20; cmd_data = BAUD_CFG; next_st = StIdle; end
      StWren:   begin cmd_data = 32'h306; next_st = StWInstr; end
      StWInstr: begin cmd_data = 32'h102; next_st = StWAddr; end
      StWAddr:  begin cmd_data = {24'h0, addr_q}; next_st = StWData; end
      StWData:  begin cmd_data = {21'h0, 3'b010, wdata_q}; next_st = StSInstr; end
      StSInstr: begin cmd_data = 32'h105; next_st = StSRecv; end
      StSRecv:  begin cmd_data = 32'h600; next_st = StSPoll; end
      StRInstr: begin cmd_data = 32'h103; next_st = StRAddr; end
      StRAddr:  begin cmd_data = {24'h0, addr_q}; next_st = StRRecv; end
      StRRecv:  begin cmd_data = 32'h600; next_st = StRPoll; end
      StSPoll, StRPoll: cmd_we = 1'b0;
      default: ;
    endcase
  end

  assign cnt_inc    = cnt_q + 16'd1;
  assign poll_st    = (state_q == StSPoll) || (state_q == StRPoll);
  assign unused_din = ^wb_din[31:9];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StInit;
      wait_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      bus_addr_q  <= '0;
      bus_dout_q  <= '0;
      bus_we_q    <= 1'b0;
      bus_cyc_q   <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid && req_ready_q) begin
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            req_ready_q <= 1'b0;
            state_q     <= req_we ? StWren : StRInstr;
          end
        end
        StDone: begin
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= StIdle;
        end
        default: begin
          if (!wait_q) begin
            bus_cyc_q  <= 1'b1;
            bus_we_q   <= cmd_we;
            bus_addr_q <= cmd_addr;
            bus_dout_q <= cmd_data;
            wait_q     <= 1'b1;
          end else if (wb_ack) begin
            bus_cyc_q <= 1'b0;
            bus_we_q  <= 1'b0;
            wait_q    <= 1'b0;
            if (poll_st) begin
              cnt_q <= cnt_inc;
              if (wb_din[8]) begin
                // A set WIP bit on a status answer restarts the whole status poll.
                if (state_q == StSPoll && wb_din[0]) begin
                  state_q <= StSInstr;
                end else begin
                  state_q     <= StDone;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b0;
                  rsp_rdata_q <= (state_q == StRPoll) ? wb_din[7:0] : 8'h00;
                end
              end else if (cnt_inc >= POLL_MAX) begin
                state_q     <= StDone;
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= 1'b1;
                rsp_rdata_q <= 8'h00;
              end
            end else begin
              state_q <= next_st;
              if (next_st == StSPoll || next_st == StRPoll) cnt_q <= '0;
              if (next_st == StIdle) req_ready_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign wb_addr   = {24'h0, bus_addr_q};
  assign wb_dout   = bus_dout_q;
  assign wb_we     = bus_we_q;
  assign wb_cyc    = bus_cyc_q;
  assign wb_stb    = bus_cyc_q;

endmodule

// File: tb/tb_spi_eeprom_sequencer.sv
// Randomized scoreboard bench: a request-level model predicts controller accesses and responses;
// a slave process and a response monitor check them as the DUT produces them.
module tb_spi_eeprom_sequencer;

  localparam logic [15:0] PollMax = 16'd4;
  localparam logic [31:0] Baud    = 32'h0000_0019;

  typedef logic [64:0] ev_t;
  typedef logic [8:0]  ans_t;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we;
  logic [7:0]  req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [7:0]  rsp_rdata;
  logic [31:0] wb_addr, wb_dout, wb_din;
  logic        wb_we, wb_stb, wb_cyc, wb_ack;

  spi_eeprom_sequencer #(.BAUD_CFG(Baud), .POLL_MAX(PollMax)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .wb_addr(wb_addr), .wb_dout(wb_dout), .wb_we(wb_we), .wb_stb(wb_stb),
    .wb_cyc(wb_cyc), .wb_din(wb_din), .wb_ack(wb_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ev_t  exp_ev[$];
  logic [8:0] exp_rsp[$];
  ans_t ans_q[$];
  ans_t m_script[$];
  int   m_k;
  int   vectors = 0, miscompares = 0;
  int   accepted = 0, responses = 0, issued = 0, aborted = 0;
  bit   inject_ack = 1'b0;

  function automatic void check(string name, logic [64:0] act, logic [64:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endfunction

  function automatic void push_w(logic [10:0] cmd);
    exp_ev.push_back({1'b1, 32'h10, 21'h0, cmd});
  endfunction

  function automatic void push_r();
    exp_ev.push_back({1'b0, 32'h10, 32'h0});
  endfunction

  // One poll loop: {rx_valid_seen, answer}; zero means the read budget ran out.
  function automatic logic [9:0] poll_model();
    ans_t a;
    for (int n = 0; n < int'(PollMax); n++) begin
      a = (m_k < m_script.size()) ? m_script[m_k] : 9'h0;
      m_k++;
      push_r();
      if (a[8]) return {1'b1, a};
    end
    return 10'h0;
  endfunction

  function automatic void model(bit we, logic [7:0] addr, logic [7:0] wdata);
    logic [9:0] r;
    bit fin;
    m_k = 0;
    if (we) begin
      push_w(11'h306); push_w(11'h102); push_w({3'b000, addr}); push_w({3'b010, wdata});
      fin = 1'b0;
      while (!fin) begin
        push_w(11'h105); push_w(11'h600);
        r = poll_model();
        if (!r[9]) begin exp_rsp.push_back({1'b1, 8'h00}); fin = 1'b1; end
        else if (!r[0]) begin exp_rsp.push_back(9'h000); fin = 1'b1; end
      end
    end else begin
      push_w(11'h103); push_w({3'b000, addr}); push_w(11'h600);
      r = poll_model();
      exp_rsp.push_back(r[9] ? {1'b0, r[7:0]} : {1'b1, 8'h00});
    end
  endfunction

  task automatic issue(bit we, logic [7:0] addr, logic [7:0] wdata);
    int guard = 0;
    do begin @(negedge clk); guard++; end while (!req_ready && guard < 2000);
    if (!req_ready) begin
      check("req_ready_timeout", 65'(req_ready), 65'(1));
      return;
    end
    req_we = we; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    model(we, addr, wdata);
    // Only the answers the model consumed are offered, so nothing leaks into the next request.
    for (int i = 0; i < m_k && i < m_script.size(); i++) ans_q.push_back(m_script[i]);
    issued++;
    @(negedge clk);
    req_valid = 1'($urandom_range(0, 1));
    req_we = 1'($urandom); req_addr = 8'($urandom); req_wdata = 8'($urandom);
  endtask

  task automatic wait_idle();
    int guard = 0;
    req_valid = 1'b0;
    do begin @(negedge clk); guard++; end
    while (!(req_ready && exp_rsp.size() == 0 && exp_ev.size() == 0) && guard < 3000);
    if (guard >= 3000) check("idle_timeout", 65'(exp_ev.size() + exp_rsp.size()), 65'(0));
  endtask

  // Wishbone slave: acks after 1-3 wait cycles, answers reads from ans_q.
  initial begin
    int   wl;
    ev_t  seen, ev;
    ans_t a;
    logic [31:0] junk;
    wl = -1; wb_ack = 1'b0; wb_din = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        wb_ack = 1'b0; wl = -1;
      end else if (wb_ack) begin
        wb_ack = 1'b0; wl = -1;
        check("bus_gap", 65'(wb_cyc), 65'(0));
      end else if (wb_cyc && wb_stb) begin
        if (wl < 0) begin
          wl = $urandom_range(1, 3);
          seen = {wb_we, wb_addr, wb_dout};
        end else begin
          wl--;
          if (wl == 0) begin
            check("bus_stable", {wb_we, wb_addr, wb_dout}, seen);
            ev = {wb_we, wb_addr, wb_we ? wb_dout : 32'h0};
            if (exp_ev.size() == 0) begin
              vectors++; miscompares++;
              $display("FAIL bus_unexpected: got %h required none", ev);
            end else begin
              check("bus_access", ev, exp_ev.pop_front());
            end
            if (!wb_we) begin
              a = (ans_q.size() > 0) ? ans_q.pop_front() : 9'h0;
              junk = $urandom;
              wb_din = {junk[31:9], a};
            end
            wb_ack = 1'b1;
          end
        end
      end else if (inject_ack) begin
        wb_ack = 1'b1; inject_ack = 1'b0;
      end
    end
  end

  // Response monitor.
  initial begin
    bit after;
    after = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        after = 1'b0;
      end else begin
        if (after) begin
          check("rsp_pulse_then_ready", 65'({rsp_valid, req_ready}), 65'(2'b01));
          after = 1'b0;
        end
        if (rsp_valid) begin
          responses++;
          after = 1'b1;
          if (exp_rsp.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL rsp_unexpected: got err=%0b rdata=%h required none", rsp_err, rsp_rdata);
          end else begin
            check("rsp", 65'({rsp_err, rsp_rdata, req_ready}), 65'({exp_rsp.pop_front(), 1'b0}));
          end
        end
      end
    end
  end

  always @(posedge clk) if (rst && req_valid && req_ready) accepted++;

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got no finish required finish within 60000 cycles");
    $fatal(1);
  end

  initial begin
    int   resp_before, guard;
    ans_t a;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_state", 65'({req_ready, wb_cyc, wb_stb, wb_we, rsp_valid, rsp_err, rsp_rdata,
                              wb_addr, wb_dout}), 65'(0));
    exp_ev.push_back({1'b1, 32'h20, Baud});
    rst = 1'b1;
    @(negedge clk);
    check("ready_low_in_init", 65'(req_ready), 65'(0));
    wait_idle();
    check("ready_after_init", 65'(req_ready), 65'(1));

    inject_ack = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_stray_ack", 65'({req_ready, wb_cyc}), 65'(2'b10));

    m_script = '{9'h103, 9'h100};
    issue(1'b1, 8'hFE, 8'hD3); wait_idle();
    m_script = '{9'h000, 9'h000, 9'h1D3};
    issue(1'b0, 8'hFE, 8'h00); wait_idle();
    m_script.delete();
    issue(1'b0, 8'h5A, 8'h00); wait_idle();

    // Reset in the middle of the address write's ack-wait.
    m_script = '{9'h100};
    issue(1'b1, 8'h3C, 8'h77);
    req_valid = 1'b0;
    guard = 0;
    do begin @(posedge clk); #1; guard++; end
    while (!(wb_cyc && wb_addr == 32'h10 && wb_dout == 32'h03C) && guard < 500);
    check("reached_w_addr", 65'(wb_cyc), 65'(1));
    resp_before = responses;
    #2 rst = 1'b0;
    #1 check("reset_drops_cyc", 65'({wb_cyc, wb_stb}), 65'(0));
    exp_ev.delete(); exp_rsp.delete(); ans_q.delete();
    aborted++;
    repeat (2) @(negedge clk);
    exp_ev.push_back({1'b1, 32'h20, Baud});
    rst = 1'b1;
    wait_idle();
    check("no_rsp_after_reset", 65'(responses), 65'(resp_before));

    for (int t = 0; t < 40; t++) begin
      m_script.delete();
      for (int j = 0; j < int'($urandom_range(0, 6)); j++) begin
        a = 9'($urandom_range(0, 511));
        case ($urandom_range(0, 2))
          0: a[8] = 1'b0;
          1: begin a[8] = 1'b1; a[0] = 1'b1; end
          default: begin a[8] = 1'b1; a[0] = 1'b0; end
        endcase
        m_script.push_back(a);
      end
      issue(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();
    check("accept_count", 65'(accepted), 65'(issued));
    check("rsp_count", 65'(responses), 65'(issued - aborted));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
